// File: rtl/counter_if.sv
// Counter bus: count-control inputs and registered count/overflow outputs.
// With COUNTER_OVF_TALLY_EN defined the bus also carries the saturating
// wrap tally ovf_tally.
interface counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             overflow;
`ifdef COUNTER_OVF_TALLY_EN
    logic [7:0]       ovf_tally;

    modport master (
        output enable, load, load_value,
        input  count, overflow, ovf_tally
    );

    modport slave (
        input  enable, load, load_value,
        output count, overflow, ovf_tally
    );
`else
    modport master (
        output enable, load, load_value,
        input  count, overflow
    );

    modport slave (
        input  enable, load, load_value,
        output count, overflow
    );
`endif
endinterface

// File: rtl/counter.sv
// Loadable, enable-gated binary up-counter, modulo 2**WIDTH, with a
// registered one-cycle overflow pulse after each MAX->0 wrap.
// Optional feature macro: COUNTER_OVF_TALLY_EN adds an 8-bit saturating
// count of wraps (ovf_tally), cleared only by rst.
module counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] CountMax = '1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    // Next state: load beats enable; wrap at MAX raises overflow for one cycle.
    always_comb begin
        count_d    = count_q;
        overflow_d = 1'b0;
        if (bus.load) begin
            count_d = bus.load_value;
        end else if (bus.enable) begin
            if (count_q == CountMax) begin
                count_d    = '0;
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

`ifdef COUNTER_OVF_TALLY_EN
    logic [7:0] tally_q, tally_d;

    // Tally bumps on every wrap edge and sticks at 255; load leaves it alone.
    always_comb begin
        tally_d = tally_q;
        if (overflow_d && (tally_q != 8'hFF)) begin
            tally_d = tally_q + 8'd1;
        end
    end

    // Tally register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tally_q <= 8'd0;
        end else begin
            tally_q <= tally_d;
        end
    end

    assign bus.ovf_tally = tally_q;
`endif

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: a vector table of directed steps, hand
// sequences for async reset and load corners, and a randomized phase
// checked against a small reference model through a scoreboard queue.
module tb_counter;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic             rst;
        logic             load;
        logic             enable;
        logic [WIDTH-1:0] load_value;
        logic [WIDTH-1:0] exp_count;
        logic             exp_ovf;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             ovf;
        logic [7:0]       tally;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    counter_if #(.WIDTH(WIDTH)) bus ();

    counter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t             sb_q[$];
    int               n_vec = 0;
    int               n_err = 0;

    // Reference model state
    logic [WIDTH-1:0] m_count = '0;
    logic             m_ovf   = 1'b0;
    logic [7:0]       m_tally = 8'd0;

    function automatic void model_step(input logic r, input logic ld, input logic en,
                                       input logic [WIDTH-1:0] lv);
        if (r) begin
            m_count = '0;
            m_ovf   = 1'b0;
            m_tally = 8'd0;
        end else if (ld) begin
            m_count = lv;
            m_ovf   = 1'b0;
        end else if (en) begin
            if (m_count == {WIDTH{1'b1}}) begin
                m_count = '0;
                m_ovf   = 1'b1;
                if (m_tally != 8'hFF) m_tally = m_tally + 8'd1;
            end else begin
                m_count = m_count + 1'b1;
                m_ovf   = 1'b0;
            end
        end else begin
            m_ovf = 1'b0;
        end
    endfunction

    task automatic compare_now(input string name, input exp_t e);
        logic bad;
        n_vec++;
        bad = (bus.count !== e.count) || (bus.overflow !== e.ovf);
`ifdef COUNTER_OVF_TALLY_EN
        bad = bad || (bus.ovf_tally !== e.tally);
        if (bad) begin
            n_err++;
            $display("FAIL %s: got count=%0d ovf=%0b tally=%0d, want count=%0d ovf=%0b tally=%0d",
                     name, bus.count, bus.overflow, bus.ovf_tally, e.count, e.ovf, e.tally);
        end
`else
        if (bad) begin
            n_err++;
            $display("FAIL %s: got count=%0d ovf=%0b, want count=%0d ovf=%0b",
                     name, bus.count, bus.overflow, e.count, e.ovf);
        end
`endif
    endtask

    task automatic pop_and_check(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got count=%0d, want a queued entry",
                     name, bus.count);
        end else begin
            e = sb_q.pop_front();
            compare_now(name, e);
        end
    endtask

    // Drive one cycle's inputs at negedge, queue the expectation, check after posedge.
    task automatic step(input string name, input logic r, input logic ld, input logic en,
                        input logic [WIDTH-1:0] lv, input logic use_exp,
                        input logic [WIDTH-1:0] ec, input logic eo);
        exp_t e;
        @(negedge clk);
        rst            = r;
        bus.load       = ld;
        bus.enable     = en;
        bus.load_value = lv;
        model_step(r, ld, en, lv);
        e.count = use_exp ? ec : m_count;
        e.ovf   = use_exp ? eo : m_ovf;
        e.tally = m_tally;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        pop_and_check(name);
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic ld, input logic en,
                                input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] ec,
                                input logic eo);
        vec_t v;
        v.rst = r; v.load = ld; v.enable = en; v.load_value = lv;
        v.exp_count = ec; v.exp_ovf = eo;
        return v;
    endfunction

    initial begin
        exp_t e;
        logic [WIDTH-1:0] lv;

        rst            = 1'b1;
        bus.load       = 1'b0;
        bus.enable     = 1'b0;
        bus.load_value = '0;

        // Reset, then wrap from 250
        vecs.push_back(mk(1, 0, 0, 8'd0,   8'd0,   0));
        vecs.push_back(mk(0, 1, 0, 8'd250, 8'd250, 0));
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(0, 0, 1, 8'd0, 8'(250 + i), 0));
        vecs.push_back(mk(0, 0, 1, 8'd0,   8'd0,   1));
        vecs.push_back(mk(0, 0, 1, 8'd0,   8'd1,   0));
        // Second wrap: load 253 with enable high (load wins)
        vecs.push_back(mk(0, 1, 1, 8'd253, 8'd253, 0));
        vecs.push_back(mk(0, 0, 1, 8'd0,   8'd254, 0));
        vecs.push_back(mk(0, 0, 1, 8'd0,   8'd255, 0));
        vecs.push_back(mk(0, 0, 1, 8'd0,   8'd0,   1));
        vecs.push_back(mk(0, 0, 0, 8'd0,   8'd0,   0));
        // Disabled at MAX holds
        vecs.push_back(mk(0, 1, 0, 8'd255, 8'd255, 0));
        vecs.push_back(mk(0, 0, 0, 8'd0,   8'd255, 0));
        vecs.push_back(mk(0, 0, 0, 8'd0,   8'd255, 0));
        // Load priority at MAX with enable high
        vecs.push_back(mk(0, 1, 1, 8'd7,   8'd7,   0));
        vecs.push_back(mk(0, 0, 1, 8'd0,   8'd8,   0));
        vecs.push_back(mk(0, 0, 0, 8'd0,   8'd8,   0));
        // Sync-sampled reset mid-count, then resume from 0
        vecs.push_back(mk(1, 0, 1, 8'd0,   8'd0,   0));
        vecs.push_back(mk(0, 0, 1, 8'd0,   8'd1,   0));
        vecs.push_back(mk(0, 1, 0, 8'd100, 8'd100, 0));

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].load, vecs[i].enable,
                 vecs[i].load_value, 1'b1, vecs[i].exp_count, vecs[i].exp_ovf);
        end

        // Async reset with overflow high: both clear before the next edge
        step("pre_max",  0, 1, 0, 8'd255, 1'b1, 8'd255, 0);
        step("pre_wrap", 0, 0, 1, 8'd0,   1'b1, 8'd0,   1);
        @(negedge clk);
        bus.enable = 1'b1;
        rst        = 1'b1;
        model_step(1'b1, 1'b0, 1'b1, '0);
        #1;
        e.count = '0; e.ovf = 1'b0; e.tally = 8'd0;
        compare_now("async_rst_ovf", e);
        step("pre_cnt", 0, 1, 1, 8'd40, 1'b1, 8'd40, 0);
        step("pre_cnt2", 0, 0, 1, 8'd0, 1'b1, 8'd41, 0);
        @(negedge clk);
        rst = 1'b1;
        model_step(1'b1, 1'b0, 1'b1, '0);
        #1;
        compare_now("async_rst_cnt", e);
        for (int i = 0; i < 3; i++) step($sformatf("rst_hold%0d", i), 1, 0, 1, 8'd0, 1'b1, 8'd0, 0);
        step("rst_release", 0, 0, 1, 8'd0, 1'b1, 8'd1, 0);

`ifdef COUNTER_OVF_TALLY_EN
        // Three wraps, load keeps the tally, reset clears it
        step("tally_rst", 1, 0, 0, 8'd0, 1'b1, 8'd0, 0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("tally_ld%0d", i), 0, 1, 0, 8'd255, 1'b1, 8'd255, 0);
            step($sformatf("tally_wrap%0d", i), 0, 0, 1, 8'd0, 1'b1, 8'd0, 1);
        end
        n_vec++;
        if (bus.ovf_tally !== 8'd3) begin
            n_err++;
            $display("FAIL tally_three: got %0d, want 3", bus.ovf_tally);
        end
        step("tally_load", 0, 1, 0, 8'd9, 1'b1, 8'd9, 0);
        n_vec++;
        if (bus.ovf_tally !== 8'd3) begin
            n_err++;
            $display("FAIL tally_after_load: got %0d, want 3", bus.ovf_tally);
        end
        step("tally_clear", 1, 0, 0, 8'd0, 1'b1, 8'd0, 0);
        n_vec++;
        if (bus.ovf_tally !== 8'd0) begin
            n_err++;
            $display("FAIL tally_after_rst: got %0d, want 0", bus.ovf_tally);
        end
`endif

        // Randomized phase checked against the model
        step("rand_rst", 1, 0, 0, 8'd0, 1'b0, 8'd0, 0);
        for (int i = 0; i < 400; i++) begin
            lv = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : 8'(250 + $urandom_range(0, 5));
            step($sformatf("rand%0d", i), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 lv, 1'b0, 8'd0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, want completion");
        $fatal(1);
    end

endmodule
